// File: rtl/tt_pkg.sv
// Shared types and defaults for the truth-table sweep engine and its golden lookup.
package tt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } tt_state_t;

    localparam int         TT_DEFAULT_N_IN  = 3;
    localparam logic [7:0] TT_DEFAULT_TABLE = 8'b00111001;

endpackage

// File: rtl/tt_expected.sv
// Golden model lookup: expected DUT output for vector i_idx is TRUTH_TABLE[i_idx].
module tt_expected
    import tt_pkg::*;
#(
    parameter int                      N_IN        = TT_DEFAULT_N_IN,
    parameter logic [(1<<N_IN)-1:0]    TRUTH_TABLE = TT_DEFAULT_TABLE
) (
    input  logic [N_IN-1:0] i_idx,
    output logic            o_expected
);

    assign o_expected = TRUTH_TABLE[i_idx];

endmodule

// File: rtl/truth_table_tester.sv
// Sweeps all input vectors onto x_out, samples z_in after SETTLE_CYCLES and counts mismatches.
// Optional macro TT_STOP_ON_FAIL_EN ends the sweep at the first mismatching vector.
module truth_table_tester
    import tt_pkg::*;
#(
    parameter int                   N_IN          = TT_DEFAULT_N_IN,
    parameter logic [(1<<N_IN)-1:0] TRUTH_TABLE   = TT_DEFAULT_TABLE,
    parameter int                   SETTLE_CYCLES = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic            z_in,
    output logic [N_IN-1:0] x_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic            fail_valid,
    output logic [N_IN-1:0] first_fail_idx
);

`ifdef TT_STOP_ON_FAIL_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif

    // SETTLE_CYCLES is limited to 1..15 so the settle counter fits in 4 bits.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    tt_state_t       r_state;
    tt_state_t       w_next;
    logic [N_IN-1:0] r_idx;
    logic [3:0]      r_settle;
    logic [N_IN:0]   r_err;
    logic            r_fail_valid;
    logic [N_IN-1:0] r_first_fail;
    logic            r_pass;

    logic            w_expected;
    logic            w_mismatch;
    logic            w_last_vec;
    logic [N_IN:0]   w_err_next;

    tt_expected #(
        .N_IN        (N_IN),
        .TRUTH_TABLE (TRUTH_TABLE)
    ) u_expected (
        .i_idx      (r_idx),
        .o_expected (w_expected)
    );

    // Case inequality so an unknown z_in is scored as a failure.
    assign w_mismatch = (z_in !== w_expected);
    assign w_last_vec = (r_idx == '1);
    assign w_err_next = r_err + {{N_IN{1'b0}}, w_mismatch};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        x_out  = '0;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = APPLY;
                end
            end
            APPLY: begin
                busy  = 1'b1;
                x_out = r_idx;
                if (r_settle == SETTLE_LAST) begin
                    w_next = CHECK;
                end
            end
            CHECK: begin
                busy  = 1'b1;
                x_out = r_idx;
                if ((STOP_ON_FAIL && w_mismatch) || w_last_vec) begin
                    w_next = DONE;
                end else begin
                    w_next = APPLY;
                end
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_idx        <= '0;
            r_settle     <= '0;
            r_err        <= '0;
            r_fail_valid <= 1'b0;
            r_first_fail <= '0;
            r_pass       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_settle <= '0;
                    if (start) begin
                        r_idx        <= '0;
                        r_err        <= '0;
                        r_fail_valid <= 1'b0;
                        r_first_fail <= '0;
                        r_pass       <= 1'b0;
                    end
                end
                APPLY: begin
                    r_settle <= (r_settle == SETTLE_LAST) ? 4'd0 : r_settle + 4'd1;
                end
                CHECK: begin
                    r_err <= w_err_next;
                    if (w_mismatch && !r_fail_valid) begin
                        r_fail_valid <= 1'b1;
                        r_first_fail <= r_idx;
                    end
                    // pass must already reflect this final check while done is high.
                    if (w_next == DONE) begin
                        r_pass <= (w_err_next == '0);
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign pass           = r_pass;
    assign err_count      = r_err;
    assign fail_valid     = r_fail_valid;
    assign first_fail_idx = r_first_fail;

endmodule

// File: tb/tb_truth_table_tester.sv
// Scoreboarded bench: stimulus queues expected sweep results, monitors score them on each done pulse.
module tb_truth_table_tester;
    import tt_pkg::*;

`ifdef TT_STOP_ON_FAIL_EN
    localparam bit SOF = 1'b1;
`else
    localparam bit SOF = 1'b0;
`endif

    typedef struct {
        int err;
        int ffi;
        int fv;
        int pass;
        int done_cyc;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       start3 = 1'b0;
    logic       z_in, z3;
    logic [2:0] x_out, x3;
    logic       busy, done, pass, busy3, done3, pass3;
    logic [3:0] err_count, err3;
    logic       fail_valid, fv3;
    logic [2:0] first_fail_idx, ffi3;

    logic [7:0] tbl = 8'b00111001;
    int         mode = 0;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    int         n_done = 0;
    exp_t       q[$];
    exp_t       q3[$];
    exp_t       em, em3;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    truth_table_tester u_dut (
        .clock(clock), .reset(reset), .start(start), .z_in(z_in),
        .x_out(x_out), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_valid(fail_valid), .first_fail_idx(first_fail_idx)
    );

    truth_table_tester #(.SETTLE_CYCLES(3)) u_dut3 (
        .clock(clock), .reset(reset), .start(start3), .z_in(z3),
        .x_out(x3), .busy(busy3), .done(done3), .pass(pass3),
        .err_count(err3), .fail_valid(fv3), .first_fail_idx(ffi3)
    );

    // Modelled DUT: 0 correct, 1 stuck at 0, 2 inverted, 3 stuck at 1 on vector 6 only.
    always_comb begin
        case (mode)
            1:       z_in = 1'b0;
            2:       z_in = ~tbl[x_out];
            3:       z_in = (x_out == 3'd6) ? 1'b1 : tbl[x_out];
            default: z_in = tbl[x_out];
        endcase
        z3 = (x3 == 3'd6) ? 1'b1 : tbl[x3];
    end

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clock) begin
        if (!reset && done) begin
            n_done++;
            if (q.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                em = q.pop_front();
                chk("err_count", int'(err_count), em.err);
                chk("first_fail_idx", int'(first_fail_idx), em.ffi);
                chk("fail_valid", int'(fail_valid), em.fv);
                chk("pass", int'(pass), em.pass);
                chk("done_cycle", cyc, em.done_cyc);
            end
        end
    end

    always @(negedge clock) begin
        if (!reset && done3) begin
            if (q3.size() == 0) begin
                chk("spurious_done3", 1, 0);
            end else begin
                em3 = q3.pop_front();
                chk("err3", int'(err3), em3.err);
                chk("ffi3", int'(ffi3), em3.ffi);
                chk("fv3", int'(fv3), em3.fv);
                chk("pass3", int'(pass3), em3.pass);
                chk("done_cycle3", cyc, em3.done_cyc);
            end
        end
    end

    // Pulses start on the chosen instance, queues the expected result, returns the sampling cycle.
    task automatic launch(input bit which, input int err, input int ffi, input int fv,
                          input int ps, input int lat, output int c);
        exp_t e;
        @(negedge clock);
        if (which) start3 = 1'b1; else start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        start3 = 1'b0;
        c = cyc;
        e.err = err; e.ffi = ffi; e.fv = fv; e.pass = ps; e.done_cyc = c + lat;
        if (which) q3.push_back(e); else q.push_back(e);
    endtask

    task automatic wait_done(input bit which, input int limit);
        int t = 0;
        while (((which ? q3.size() : q.size()) != 0 || (which ? busy3 : busy)) && t < limit) begin
            @(negedge clock);
            t++;
        end
        chk("sweep_timeout", (t >= limit) ? 1 : 0, 0);
        @(negedge clock);
    endtask

    initial begin
        int c;
        int t;
        int d0;
        repeat (3) @(negedge clock);
        chk("rst_x_out", int'(x_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pass", int'(pass), 0);
        chk("rst_err_count", int'(err_count), 0);
        chk("rst_fail_valid", int'(fail_valid), 0);
        chk("rst_first_fail_idx", int'(first_fail_idx), 0);
        reset = 1'b0;

        // 1: correct DUT, x_out walks 0..7 with each vector held two cycles.
        mode = 0;
        launch(0, 0, 0, 0, 1, 16, c);
        for (int k = 0; k < 16; k++) begin
            @(negedge clock);
            chk("x_out_seq", int'(x_out), k / 2);
            chk("busy_seq", int'(busy), 1);
        end
        wait_done(0, 40);
        repeat (3) @(negedge clock);
        chk("pass_hold_idle", int'(pass), 1);

        // 2: stuck-at-0 output misses vectors 0,3,4,5.
        mode = 1;
        launch(0, SOF ? 1 : 4, 0, 1, 0, SOF ? 2 : 16, c);
        chk("pass_cleared_at_start", int'(pass), 0);
        wait_done(0, 40);
        repeat (3) @(negedge clock);
        chk("err_hold_idle", int'(err_count), SOF ? 1 : 4);
        chk("fv_hold_idle", int'(fail_valid), 1);

        // 3: inverted output fails everywhere, then a clean sweep restores pass.
        mode = 2;
        launch(0, SOF ? 1 : 8, 0, 1, 0, SOF ? 2 : 16, c);
        wait_done(0, 40);
        mode = 0;
        launch(0, 0, 0, 0, 1, 16, c);
        wait_done(0, 40);

        // 4: single fault at vector 6 with three settle cycles.
        launch(1, 1, 6, 1, 0, SOF ? 28 : 32, c);
        wait_done(1, 60);

        // 5a: start re-pulsed mid-sweep must be ignored.
        mode = 0;
        d0 = n_done;
        launch(0, 0, 0, 0, 1, 16, c);
        repeat (2) @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (5) @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_done(0, 40);
        repeat (20) @(negedge clock);
        chk("single_done_pulse", n_done - d0, 1);

        // 5b: reset at vector 4 drops everything immediately.
        d0 = n_done;
        launch(0, 0, 0, 0, 1, 16, c);
        t = 0;
        while (x_out != 3'd4 && t < 40) begin
            @(negedge clock);
            t++;
        end
        chk("reach_vec4", int'(x_out), 4);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_x_out", int'(x_out), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_err", int'(err_count), 0);
        chk("mid_rst_pass", int'(pass), 0);
        void'(q.pop_back());
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        repeat (20) @(negedge clock);
        chk("no_done_after_reset", n_done - d0, 0);

        // 5c: next sweep starts again from vector 0.
        launch(0, 0, 0, 0, 1, 16, c);
        @(negedge clock);
        chk("restart_vec0", int'(x_out), 0);
        wait_done(0, 40);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
